// File: rtl/axi_ram_bridge_pkg.sv
// Shared AXI constants, FSM state encoding and strobe helpers for the RAM bridge.
package axi_pkg;

    localparam logic [1:0] OKAY   = 2'b00;
    localparam logic [1:0] SLVERR = 2'b10;

    localparam logic [1:0] FIXED = 2'b00;
    localparam logic [1:0] INCR  = 2'b01;
    localparam logic [1:0] WRAP  = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD_ISSUE,
        RD_WAIT,
        RD_DATA,
        WR_DATA,
        WR_RESP
    } state_t;

    // Each strobe bit enables one full byte lane of the 64-bit RAM mask.
    function automatic logic [63:0] strb_to_mask(input logic [7:0] strb);
        logic [63:0] m;
        m = '0;
        for (int i = 0; i < 8; i++) begin
            m[i*8 +: 8] = {8{strb[i]}};
        end
        return m;
    endfunction

    // Anything wider than the 64-bit bus, WRAP, or the reserved burst code is rejected.
    function automatic logic burst_err(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd3) || (burst == WRAP) || (burst == 2'b11);
    endfunction

endpackage

// File: rtl/axi_ram_bridge_if.sv
// AXI4 bus bundle between the core/crossbar (master) and the RAM bridge (slave).
interface axi_ram_bridge_if #(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
);
    logic              awvalid;
    logic              awready;
    logic [ADDR_W-1:0] awaddr;
    logic [ID_W-1:0]   awid;
    logic [7:0]        awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;

    logic              wvalid;
    logic              wready;
    logic [63:0]       wdata;
    logic [7:0]        wstrb;
    logic              wlast;

    logic              bvalid;
    logic              bready;
    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;

    logic              arvalid;
    logic              arready;
    logic [ADDR_W-1:0] araddr;
    logic [ID_W-1:0]   arid;
    logic [7:0]        arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;

    logic              rvalid;
    logic              rready;
    logic [63:0]       rdata;
    logic [ID_W-1:0]   rid;
    logic [1:0]        rresp;
    logic              rlast;

    modport master (
        output awvalid, awaddr, awid, awlen, awsize, awburst,
        output wvalid, wdata, wstrb, wlast,
        output bready,
        output arvalid, araddr, arid, arlen, arsize, arburst,
        output rready,
        input  awready, wready, bvalid, bid, bresp,
        input  arready, rvalid, rdata, rid, rresp, rlast
    );

    modport slave (
        input  awvalid, awaddr, awid, awlen, awsize, awburst,
        input  wvalid, wdata, wstrb, wlast,
        input  bready,
        input  arvalid, araddr, arid, arlen, arsize, arburst,
        input  rready,
        output awready, wready, bvalid, bid, bresp,
        output arready, rvalid, rdata, rid, rresp, rlast
    );

endinterface

// File: rtl/axi_ram_bridge_addr_gen.sv
// Beat address for FIXED/INCR bursts; shared by the read and write paths.
module axi_burst_addr_gen
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic [ADDR_W-1:0] base,
    input  logic [2:0]        size,
    input  logic [1:0]        burst,
    input  logic [7:0]        beat,
    output logic [ADDR_W-1:0] addr
);

    // INCR steps by the beat size and wraps at ADDR_W; no 4 KB boundary handling.
    always_comb begin
        addr = base;
        if (burst == INCR) begin
            addr = base + (ADDR_W'(beat) << size);
        end
    end

endmodule

// File: rtl/axi_ram_bridge.sv
// AXI4 slave that serialises 64-bit bursts into single-beat RAMCtrl accesses.
module axi_ram_bridge
    import axi_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int ID_W   = 4
) (
    input  logic        clock,
    input  logic        reset,
    axi_ram_bridge_if.slave axi,
    output logic [63:0] ram_raddr,
    input  logic [63:0] ram_rdata,
    output logic        ram_rflag,
    output logic [63:0] ram_waddr,
    output logic [63:0] ram_wdata,
    output logic [63:0] ram_wmask,
    output logic        ram_wen
);

    state_t            state, state_nxt;
    logic              prio_rd;
    logic              rd_grant, wr_grant;
    logic              w_hs, r_hs;

    logic [ADDR_W-1:0] base_q;
    logic [2:0]        size_q;
    logic [1:0]        burst_q;
    logic [7:0]        len_q;
    logic [7:0]        beat_q;
    logic [ID_W-1:0]   id_q;
    logic              err_q;
    logic              wlast_err_q;

    logic [7:0]        gen_beat;
    logic [ADDR_W-1:0] beat_addr;

    assign w_hs = (state == WR_DATA) && axi.wvalid;
    assign r_hs = (state == RD_DATA) && axi.rready;

    // In RD_DATA the generator looks one beat ahead so the next RD_ISSUE has its address ready.
    assign gen_beat = (state == RD_DATA) ? beat_q + 8'd1 : beat_q;

    axi_burst_addr_gen #(.ADDR_W(ADDR_W)) u_addr_gen (
        .base  (base_q),
        .size  (size_q),
        .burst (burst_q),
        .beat  (gen_beat),
        .addr  (beat_addr)
    );

    // State register.
    always_ff @(posedge clock) begin
        if (reset) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state, round-robin grant and ready outputs.
    always_comb begin
        state_nxt   = state;
        rd_grant    = 1'b0;
        wr_grant    = 1'b0;
        axi.arready = 1'b0;
        axi.awready = 1'b0;
        axi.wready  = 1'b0;
        case (state)
            IDLE: begin
                rd_grant    = axi.arvalid && (!axi.awvalid || prio_rd);
                wr_grant    = axi.awvalid && !rd_grant;
                axi.arready = !wr_grant;
                axi.awready = !rd_grant;
                if (rd_grant)      state_nxt = RD_ISSUE;
                else if (wr_grant) state_nxt = WR_DATA;
            end
            RD_ISSUE: state_nxt = RD_WAIT;
            RD_WAIT:  state_nxt = RD_DATA;
            RD_DATA: begin
                if (axi.rready) state_nxt = axi.rlast ? IDLE : RD_ISSUE;
            end
            WR_DATA: begin
                axi.wready = 1'b1;
                if (axi.wvalid && (beat_q == len_q)) state_nxt = WR_RESP;
            end
            WR_RESP: begin
                if (axi.bready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
        // Nothing is accepted while reset is held.
        if (reset) begin
            rd_grant    = 1'b0;
            wr_grant    = 1'b0;
            axi.arready = 1'b0;
            axi.awready = 1'b0;
            axi.wready  = 1'b0;
        end
    end

    // Transaction context: latched at grant, beat counter, arbitration priority, sticky errors.
    always_ff @(posedge clock) begin
        if (reset) begin
            prio_rd     <= 1'b1;
            base_q      <= '0;
            size_q      <= '0;
            burst_q     <= '0;
            len_q       <= '0;
            beat_q      <= '0;
            id_q        <= '0;
            err_q       <= 1'b0;
            wlast_err_q <= 1'b0;
        end else begin
            if (rd_grant) begin
                base_q  <= axi.araddr;
                size_q  <= axi.arsize;
                burst_q <= axi.arburst;
                len_q   <= axi.arlen;
                id_q    <= axi.arid;
                err_q   <= burst_err(axi.arsize, axi.arburst);
                beat_q  <= '0;
                prio_rd <= 1'b0;
            end else if (wr_grant) begin
                base_q      <= axi.awaddr;
                size_q      <= axi.awsize;
                burst_q     <= axi.awburst;
                len_q       <= axi.awlen;
                id_q        <= axi.awid;
                err_q       <= burst_err(axi.awsize, axi.awburst);
                wlast_err_q <= 1'b0;
                beat_q      <= '0;
                prio_rd     <= 1'b1;
            end
            if (r_hs && !axi.rlast) beat_q <= beat_q + 8'd1;
            if (w_hs) begin
                beat_q <= beat_q + 8'd1;
                // awlen sets the beat count; an early wlast only poisons the response.
                if (axi.wlast && (beat_q != len_q)) wlast_err_q <= 1'b1;
            end
        end
    end

    // Read path: RAM request pulse, then capture into the held R channel registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_raddr  <= '0;
            ram_rflag  <= 1'b0;
            axi.rvalid <= 1'b0;
            axi.rdata  <= '0;
            axi.rid    <= '0;
            axi.rresp  <= '0;
            axi.rlast  <= 1'b0;
        end else begin
            ram_rflag <= 1'b0;
            // Beat 0 is the base address for both FIXED and INCR, so take it straight off AR.
            if (rd_grant && !burst_err(axi.arsize, axi.arburst)) begin
                ram_raddr <= 64'(axi.araddr);
                ram_rflag <= 1'b1;
            end
            if (r_hs && !axi.rlast && !err_q) begin
                ram_raddr <= 64'(beat_addr);
                ram_rflag <= 1'b1;
            end
            if (state == RD_WAIT) begin
                axi.rvalid <= 1'b1;
                axi.rdata  <= err_q ? 64'd0 : ram_rdata;
                axi.rresp  <= err_q ? SLVERR : OKAY;
                axi.rlast  <= (beat_q == len_q);
                axi.rid    <= id_q;
            end
            if (r_hs) axi.rvalid <= 1'b0;
        end
    end

    // Write path: one registered RAM write per W beat, then the B response.
    always_ff @(posedge clock) begin
        if (reset) begin
            ram_waddr  <= '0;
            ram_wdata  <= '0;
            ram_wmask  <= '0;
            ram_wen    <= 1'b0;
            axi.bvalid <= 1'b0;
            axi.bid    <= '0;
            axi.bresp  <= '0;
        end else begin
            ram_wen <= 1'b0;
            if (w_hs) begin
                ram_waddr <= 64'(beat_addr);
                ram_wdata <= axi.wdata;
                ram_wmask <= strb_to_mask(axi.wstrb);
                ram_wen   <= !err_q;
                if (beat_q == len_q) begin
                    axi.bvalid <= 1'b1;
                    axi.bid    <= id_q;
                    axi.bresp  <= (err_q || wlast_err_q) ? SLVERR : OKAY;
                end
            end
            if ((state == WR_RESP) && axi.bready) axi.bvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axi_ram_bridge.sv
// Directed bench for axi_ram_bridge: reads, writes, arbitration, errors, mid-burst reset.
module tb_axi_ram_bridge;
    import axi_pkg::*;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic [63:0] ram_raddr, ram_rdata, ram_waddr, ram_wdata, ram_wmask;
    logic        ram_rflag, ram_wen;

    int checks = 0;
    int errors = 0;

    logic [63:0] rq[$];
    logic [63:0] wa[$];
    logic [63:0] wm[$];
    logic [63:0] wd[$];
    string       order = "";
    int          overlap = 0;

    axi_ram_bridge_if #(.ADDR_W(32), .ID_W(4)) axi();

    axi_ram_bridge #(.ADDR_W(32), .ID_W(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .axi       (axi),
        .ram_raddr (ram_raddr),
        .ram_rdata (ram_rdata),
        .ram_rflag (ram_rflag),
        .ram_waddr (ram_waddr),
        .ram_wdata (ram_wdata),
        .ram_wmask (ram_wmask),
        .ram_wen   (ram_wen)
    );

    always #5 clock = ~clock;

    function automatic logic [63:0] ram_model(input logic [63:0] a);
        return (a == 64'h80000008) ? 64'h1122334455667788 : {32'h0BADF00D, a[31:0]};
    endfunction

    // RAM returns data the cycle after the request.
    always @(posedge clock) begin
        if (reset)          ram_rdata <= '0;
        else if (ram_rflag) ram_rdata <= ram_model(ram_raddr);
    end

    // Record RAM-side activity mid-cycle.
    always @(negedge clock) begin
        if (ram_rflag) begin
            rq.push_back(ram_raddr);
            order <= {order, "r"};
        end
        if (ram_wen) begin
            wa.push_back(ram_waddr);
            wm.push_back(ram_wmask);
            wd.push_back(ram_wdata);
            order <= {order, "w"};
        end
        if (ram_rflag && ram_wen) overlap <= overlap + 1;
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic do_ar(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [3:0] id);
        bit ok;
        ok = 1'b0;
        axi.araddr = a; axi.arlen = len; axi.arsize = sz; axi.arburst = bu; axi.arid = id;
        axi.arvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = axi.arready;
            step();
        end
        axi.arvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL ar_hs arready=0 expected 1 within 20 cycles"); end
    endtask

    task automatic do_aw(input logic [31:0] a, input logic [7:0] len, input logic [2:0] sz,
                         input logic [1:0] bu, input logic [3:0] id);
        bit ok;
        ok = 1'b0;
        axi.awaddr = a; axi.awlen = len; axi.awsize = sz; axi.awburst = bu; axi.awid = id;
        axi.awvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = axi.awready;
            step();
        end
        axi.awvalid = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL aw_hs awready=0 expected 1 within 20 cycles"); end
    endtask

    task automatic do_w(input logic [63:0] d, input logic [7:0] s, input logic l);
        bit ok;
        ok = 1'b0;
        axi.wdata = d; axi.wstrb = s; axi.wlast = l;
        axi.wvalid = 1'b1;
        for (int i = 0; i < 20 && !ok; i++) begin
            #1;
            ok = axi.wready;
            step();
        end
        axi.wvalid = 1'b0;
        axi.wlast  = 1'b0;
        checks++;
        if (!ok) begin errors++; $display("FAIL w_hs wready=0 expected 1 within 20 cycles"); end
    endtask

    task automatic take_b(input logic [1:0] resp, input logic [3:0] id, input string name);
        for (int i = 0; i < 20 && !axi.bvalid; i++) step();
        checks++;
        if ({axi.bvalid, axi.bresp, axi.bid} !== {1'b1, resp, id}) begin
            errors++;
            $display("FAIL %s got bvalid=%0b bresp=%0d bid=%0d want 1/%0d/%0d",
                     name, axi.bvalid, axi.bresp, axi.bid, resp, id);
        end
        axi.bready = 1'b1;
        step();
        axi.bready = 1'b0;
    endtask

    task automatic take_r(input logic [63:0] d, input logic [1:0] resp, input logic last,
                          input logic [3:0] id, input int stall, input string name);
        logic [71:0] want;
        want = {1'b1, d, resp, last, id};
        for (int i = 0; i < 20 && !axi.rvalid; i++) step();
        checks++;
        if ({axi.rvalid, axi.rdata, axi.rresp, axi.rlast, axi.rid} !== want) begin
            errors++;
            $display("FAIL %s got v=%0b d=%h resp=%0d last=%0b id=%0d want d=%h resp=%0d last=%0b id=%0d",
                     name, axi.rvalid, axi.rdata, axi.rresp, axi.rlast, axi.rid, d, resp, last, id);
        end
        for (int s = 0; s < stall; s++) begin
            step();
            checks++;
            if ({axi.rvalid, axi.rdata, axi.rresp, axi.rlast, axi.rid} !== want) begin
                errors++;
                $display("FAIL %s_stall%0d got v=%0b d=%h want d=%h held", name, s, axi.rvalid, axi.rdata, d);
            end
        end
        axi.rready = 1'b1;
        step();
        axi.rready = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        step(); step();
        checks++;
        if ({axi.arready, axi.awready, axi.wready, axi.rvalid, axi.bvalid, ram_rflag, ram_wen,
             axi.rlast, axi.rresp, axi.bresp, axi.rid, axi.bid} !== '0) begin
            errors++; $display("FAIL reset_ctrl some valid/ready/resp/id nonzero, want all 0");
        end
        checks++;
        if ({ram_raddr, ram_waddr, ram_wdata, ram_wmask, axi.rdata} !== '0) begin
            errors++; $display("FAIL reset_data raddr=%h waddr=%h rdata=%h want 0", ram_raddr, ram_waddr, axi.rdata);
        end
        reset = 1'b0;
        #1;
        checks++;
        if ({axi.arready, axi.awready, dut.state} !== {2'b11, IDLE}) begin
            errors++; $display("FAIL reset_idle arready=%0b awready=%0b want 1/1 in IDLE", axi.arready, axi.awready);
        end
    endtask

    task automatic test_single_read();
        int c0;
        c0 = rq.size();
        do_ar(32'h80000008, 8'd0, 3'd3, INCR, 4'h3);
        checks++;
        if ({ram_rflag, ram_raddr, axi.rvalid} !== {1'b1, 64'h80000008, 1'b0}) begin
            errors++; $display("FAIL sr_issue rflag=%0b raddr=%h rvalid=%0b want 1/80000008/0", ram_rflag, ram_raddr, axi.rvalid);
        end
        step();
        checks++;
        if ({ram_rflag, axi.rvalid} !== 2'b00) begin
            errors++; $display("FAIL sr_wait rflag=%0b rvalid=%0b want 0/0", ram_rflag, axi.rvalid);
        end
        step();
        checks++;
        if (axi.rvalid !== 1'b1) begin
            errors++; $display("FAIL sr_latency rvalid=%0b want 1 in third cycle after AR", axi.rvalid);
        end
        take_r(64'h1122334455667788, OKAY, 1'b1, 4'h3, 0, "sr_data");
        checks++;
        if (rq.size() !== c0 + 1) begin
            errors++; $display("FAIL sr_pulses got %0d rflag pulses want 1", rq.size() - c0);
        end
    endtask

    task automatic test_incr_read();
        logic [63:0] exp_a[4];
        exp_a = '{64'h80000000, 64'h80000008, 64'h80000010, 64'h80000018};
        rq.delete();
        do_ar(32'h80000000, 8'd3, 3'd3, INCR, 4'h5);
        take_r(64'h0BADF00D80000000, OKAY, 1'b0, 4'h5, 0, "ir_b0");
        take_r(64'h1122334455667788, OKAY, 1'b0, 4'h5, 2, "ir_b1");
        take_r(64'h0BADF00D80000010, OKAY, 1'b0, 4'h5, 0, "ir_b2");
        take_r(64'h0BADF00D80000018, OKAY, 1'b1, 4'h5, 0, "ir_b3");
        checks++;
        if (rq.size() !== 4) begin
            errors++; $display("FAIL ir_count got %0d reads want 4", rq.size());
        end else begin
            for (int i = 0; i < 4; i++) begin
                checks++;
                if (rq[i] !== exp_a[i]) begin
                    errors++; $display("FAIL ir_addr%0d got %h want %h", i, rq[i], exp_a[i]);
                end
            end
        end
    endtask

    task automatic test_write_strobe();
        wa.delete(); wm.delete(); wd.delete();
        do_aw(32'h80000100, 8'd0, 3'd3, INCR, 4'h6);
        do_w(64'hAABBCCDD11223344, 8'h0F, 1'b1);
        checks++;
        if ({ram_wen, ram_waddr, ram_wmask, ram_wdata} !==
            {1'b1, 64'h80000100, 64'h00000000FFFFFFFF, 64'hAABBCCDD11223344}) begin
            errors++; $display("FAIL ws_beat wen=%0b waddr=%h wmask=%h wdata=%h", ram_wen, ram_waddr, ram_wmask, ram_wdata);
        end
        take_b(OKAY, 4'h6, "ws_bresp");
        checks++;
        if (wa.size() !== 1) begin
            errors++; $display("FAIL ws_pulses got %0d wen pulses want 1", wa.size());
        end
    endtask

    task automatic test_arbitration();
        int base_len;
        base_len = order.len();
        for (int k = 0; k < 2; k++) begin
            axi.araddr = 32'h80000020; axi.arlen = 8'd0; axi.arsize = 3'd3; axi.arburst = INCR; axi.arid = 4'h1;
            axi.awaddr = 32'h80000200; axi.awlen = 8'd0; axi.awsize = 3'd3; axi.awburst = INCR; axi.awid = 4'h2;
            axi.arvalid = 1'b1;
            axi.awvalid = 1'b1;
            #1;
            checks++;
            if ({axi.arready, axi.awready} !== 2'b10) begin
                errors++; $display("FAIL arb%0d_grant arready=%0b awready=%0b want 1/0", k, axi.arready, axi.awready);
            end
            step();
            axi.arvalid = 1'b0;
            take_r(64'h0BADF00D80000020, OKAY, 1'b1, 4'h1, 0, "arb_r");
            do_aw(32'h80000200, 8'd0, 3'd3, INCR, 4'h2);
            do_w(64'h0123456789ABCDEF, 8'hFF, 1'b1);
            take_b(OKAY, 4'h2, "arb_b");
        end
        step();
        checks++;
        if (order.substr(base_len, base_len + 3) != "rwrw") begin
            errors++; $display("FAIL arb_order got %s want rwrw", order.substr(base_len, order.len() - 1));
        end
        checks++;
        if (overlap !== 0) begin
            errors++; $display("FAIL arb_overlap got %0d overlapping cycles want 0", overlap);
        end
    endtask

    task automatic test_err_read();
        int c0;
        c0 = rq.size();
        do_ar(32'h80000040, 8'd1, 3'd3, WRAP, 4'h7);
        take_r(64'd0, SLVERR, 1'b0, 4'h7, 0, "er_b0");
        take_r(64'd0, SLVERR, 1'b1, 4'h7, 0, "er_b1");
        checks++;
        if (rq.size() !== c0) begin
            errors++; $display("FAIL er_noram got %0d rflag pulses want 0", rq.size() - c0);
        end
    endtask

    task automatic test_err_wlast();
        wa.delete(); wm.delete(); wd.delete();
        do_aw(32'h80000300, 8'd1, 3'd3, INCR, 4'h8);
        do_w(64'h0101010101010101, 8'hFF, 1'b1);
        do_w(64'h0202020202020202, 8'hFF, 1'b1);
        take_b(SLVERR, 4'h8, "ew_bresp");
        step();
        checks++;
        if ((wa.size() != 2) || (wa[0] !== 64'h80000300) || (wa[1] !== 64'h80000308)) begin
            errors++; $display("FAIL ew_writes got %0d pulses want 2 at 80000300/80000308", wa.size());
        end
    endtask

    task automatic test_reset_mid();
        wa.delete(); wm.delete(); wd.delete();
        do_aw(32'h80000400, 8'd3, 3'd3, INCR, 4'h9);
        do_w(64'h1111111111111111, 8'hFF, 1'b0);
        do_w(64'h2222222222222222, 8'hFF, 1'b0);
        axi.wdata = 64'h3333333333333333; axi.wstrb = 8'hFF; axi.wlast = 1'b0;
        axi.wvalid = 1'b1;
        reset = 1'b1;
        step();
        checks++;
        if ({axi.rvalid, axi.bvalid, ram_wen, ram_rflag, axi.arready, axi.awready, axi.wready} !== 7'b0) begin
            errors++; $display("FAIL rm_quiet rv=%0b bv=%0b wen=%0b rflag=%0b want all 0", axi.rvalid, axi.bvalid, ram_wen, ram_rflag);
        end
        checks++;
        if (dut.state !== IDLE) begin
            errors++; $display("FAIL rm_state got %0d want IDLE", dut.state);
        end
        reset = 1'b0;
        axi.wvalid = 1'b0;
        step();
        checks++;
        if ((ram_wen !== 1'b0) || (wa.size() != 2)) begin
            errors++; $display("FAIL rm_nowrite wen=%0b pulses=%0d want 0/2", ram_wen, wa.size());
        end
        do_ar(32'h80000008, 8'd0, 3'd3, INCR, 4'hA);
        take_r(64'h1122334455667788, OKAY, 1'b1, 4'hA, 0, "rm_read");
    endtask

    initial begin
        axi.awvalid = 1'b0; axi.awaddr = '0; axi.awid = '0; axi.awlen = '0; axi.awsize = '0; axi.awburst = '0;
        axi.wvalid = 1'b0; axi.wdata = '0; axi.wstrb = '0; axi.wlast = 1'b0;
        axi.bready = 1'b0;
        axi.arvalid = 1'b0; axi.araddr = '0; axi.arid = '0; axi.arlen = '0; axi.arsize = '0; axi.arburst = '0;
        axi.rready = 1'b0;
        test_reset();
        test_single_read();
        test_incr_read();
        test_write_strobe();
        test_arbitration();
        test_err_read();
        test_err_wlast();
        test_reset_mid();
        step();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not finish");
        $fatal(1);
    end

endmodule
